intra_transform_scheduler: RTL

INTRA_TRANSFORM_SCHEDULER -- requirements
Module: intra_transform_scheduler

---
 rtl/intra_transform_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/intra_transform_scheduler.sv
// Intra transform scheduler: admits block descriptors, forwards residual
// beats into the transform chain and retires reconstructed blocks in order.
module intra_transform_scheduler #(
  parameter int max_outstanding_g = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [7:0]   job_in_rsc_dat,
  input  logic         job_in_rsc_vld,
  output logic         job_in_rsc_rdy,
  input  logic [287:0] src_rsc_dat,
  input  logic         src_rsc_vld,
  output logic         src_rsc_rdy,
  output logic [287:0] resid_in_rsc_dat,
  output logic         resid_in_rsc_vld,
  input  logic         resid_in_rsc_rdy,
  input  logic [255:0] rec_in_rsc_dat,
  input  logic         rec_in_rsc_vld,
  output logic         rec_in_rsc_rdy,
  output logic [255:0] rec_out_rsc_dat,
  output logic         rec_out_rsc_vld,
  input  logic         rec_out_rsc_rdy,
  output logic [7:0]   done_rsc_dat,
  output logic         done_rsc_vld,
  input  logic         done_rsc_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } state_t;

  localparam logic [2:0] max_c = 3'(max_outstanding_g);

  function automatic logic [5:0] beats(
    input logic [1:0] sz
  );
    logic [5:0] n;
    unique case (sz)
      2'd0:    n = 6'd1;
      2'd1:    n = 6'd2;
      2'd2:    n = 6'd8;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] issue_cnt_q, issue_cnt_d;
  logic [5:0] ret_cnt_q;
  logic [5:0] ret_rem;
  logic [2:0] outst_q;
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] fifo_cnt_q;
  logic [7:0] done_q;
  logic       done_full_q;

  logic       fifo_empty, fifo_full;
  logic [7:0] head;
  logic       can_admit, job_fire, src_fire;
  logic       rec_gate, rec_fire, retire;

  assign fifo_empty = fifo_cnt_q == 3'd0;
  assign fifo_full  = fifo_cnt_q == 3'd4;
  assign head       = fifo_q[rd_ptr_q];
  assign can_admit  = (outst_q < max_c) && !fifo_full;

  assign job_in_rsc_rdy = arst_n && (state_q == IDLE) && can_admit;
  assign job_fire       = job_in_rsc_vld && job_in_rsc_rdy;

  assign src_rsc_rdy      = (state_q == ISSUE) && resid_in_rsc_rdy;
  assign resid_in_rsc_vld = (state_q == ISSUE) && src_rsc_vld;
  assign resid_in_rsc_dat = src_rsc_dat;
  assign src_fire         = src_rsc_vld && src_rsc_rdy;

  // A full done register that cannot drain blocks the whole retire path.
  assign rec_gate        = !fifo_empty && !(done_full_q && !done_rsc_rdy);
  assign rec_in_rsc_rdy  = rec_out_rsc_rdy && rec_gate;
  assign rec_out_rsc_vld = rec_in_rsc_vld && rec_gate;
  assign rec_out_rsc_dat = rec_in_rsc_dat;
  assign rec_fire        = rec_in_rsc_vld && rec_in_rsc_rdy;

  // Zero means the head block has not started; load its beat count.
  assign ret_rem = (ret_cnt_q == 6'd0) ? beats(head[1:0]) : ret_cnt_q;
  assign retire  = rec_fire && (ret_rem == 6'd1);

  assign done_rsc_vld = done_full_q;
  assign done_rsc_dat = done_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (job_fire) begin
          issue_cnt_d = beats(job_in_rsc_dat[1:0]);
          state_d     = ISSUE;
        end else if (!can_admit && !retire) begin
          state_d = STALL;
        end
      end
      ISSUE: begin
        if (src_fire) begin
          issue_cnt_d = issue_cnt_q - 6'd1;
          if (issue_cnt_q == 6'd1) state_d = IDLE;
        end
      end
      STALL: begin
        if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      done_q      <= '0;
      done_full_q <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      if (rec_fire) ret_cnt_q <= ret_rem - 6'd1;
      if (job_fire) begin
        fifo_q[wr_ptr_q] <= job_in_rsc_dat;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (retire) rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({job_fire, retire})
        2'b10: begin
          fifo_cnt_q <= fifo_cnt_q + 3'd1;
          outst_q    <= outst_q + 3'd1;
        end
        2'b01: begin
          fifo_cnt_q <= fifo_cnt_q - 3'd1;
          outst_q    <= outst_q - 3'd1;
        end
        default: ;
      endcase
      if (retire) begin
        done_q      <= head;
        done_full_q <= 1'b1;
      end else if (done_rsc_rdy) begin
        done_full_q <= 1'b0;
      end
    end
  end

endmodule
